// File: rtl/led_seq_ctrl_if.sv
// Board-side signal bundle for the LED sequencer: raw button in, LED bank and mode out.
`timescale 1ns/1ps
interface led_seq_ctrl_if;
  logic       btn;
  logic       LD1;
  logic       LD2;
  logic       LD3;
  logic       LD4;
  logic [1:0] mode;

  // Board / testbench side drives the button and watches the LEDs.
  modport master (output btn, input LD1, LD2, LD3, LD4, mode);
  // Sequencer side.
  modport slave  (input btn, output LD1, LD2, LD3, LD4, mode);
endinterface

// File: rtl/led_seq_ctrl.sv
// Four-LED pattern sequencer: button synchronizer + debouncer, step prescaler,
// and a mode FSM cycling ROT_L -> ROT_R -> BOUNCE -> COUNT on each debounced press.
`timescale 1ns/1ps
module led_seq_ctrl #(
  parameter int LOG2DELAY     = 16,
  parameter int DEBOUNCE_BITS = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  led_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
  logic                     deb_q, deb_d;
  logic [LOG2DELAY-1:0]     pre_q, pre_d;
  logic [3:0]               pat_q, pat_d;
  mode_e                    mode_q, mode_d;
  logic                     dir_right_q, dir_right_d;
  logic                     btn_s;
  logic                     press;
  logic                     tick;

  // Pattern each mode starts from when it is entered.
  function automatic logic [3:0] init_pat(input mode_e m);
    case (m)
      ROT_R:   init_pat = 4'b1000;
      COUNT:   init_pat = 4'b0000;
      default: init_pat = 4'b0001;
    endcase
  endfunction

  // Two-flop synchronizer and debouncer; press fires once per accepted rising change.
  always_comb begin
    sync1_d   = bus.btn;
    sync2_d   = sync1_q;
    btn_s     = sync2_q;
    press     = 1'b0;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (btn_s != deb_q) begin
      if (&deb_cnt_q) begin
        deb_d = btn_s;
        press = btn_s;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Mode advance and pattern stepping; a press restarts the new mode and discards a coincident tick.
  always_comb begin
    tick        = &pre_q;
    mode_d      = mode_q;
    pat_d       = pat_q;
    dir_right_d = dir_right_q;
    pre_d       = pre_q + 1'b1;
    if (press) begin
      mode_d      = mode_e'(mode_q + 2'd1);
      pat_d       = init_pat(mode_d);
      dir_right_d = 1'b0;
      pre_d       = '0;
    end else if (tick) begin
      case (mode_q)
        ROT_L: pat_d = {pat_q[2:0], pat_q[3]};
        ROT_R: pat_d = {pat_q[0], pat_q[3:1]};
        BOUNCE: begin
          if (!dir_right_q) begin
            pat_d = {pat_q[2:0], 1'b0};
            if (pat_d == 4'b1000) dir_right_d = 1'b1;
          end else begin
            pat_d = {1'b0, pat_q[3:1]};
            if (pat_d == 4'b0001) dir_right_d = 1'b0;
          end
        end
        default: pat_d = pat_q + 4'd1;
      endcase
    end
  end

  // All state, including the mode FSM, with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_cnt_q   <= '0;
      deb_q       <= 1'b0;
      pre_q       <= '0;
      pat_q       <= 4'b0001;
      mode_q      <= ROT_L;
      dir_right_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_q       <= deb_d;
      pre_q       <= pre_d;
      pat_q       <= pat_d;
      mode_q      <= mode_d;
      dir_right_q <= dir_right_d;
    end
  end

  assign bus.LD1  = pat_q[3];
  assign bus.LD2  = pat_q[2];
  assign bus.LD3  = pat_q[1];
  assign bus.LD4  = pat_q[0];
  assign bus.mode = mode_q;

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Pattern sequencer and mode controller for the iCEblink40-LP1K four-LED bank (LD1..LD4). It owns the step prescaler, the debounced user button and a mode FSM that selects between four LED patterns: rotate-left, rotate-right, bounce and binary count. It sits between the board clock/button pins and the LED pins. It replaces free-running single-pattern drivers with one controlled, resettable source.

## Interface

Parameters:
- LOG2DELAY, 16: a step tick occurs every 2^LOG2DELAY clocks.
- DEBOUNCE_BITS, 14: the button must differ from its debounced state for 2^DEBOUNCE_BITS consecutive clocks before the change is accepted.

Ports:
- clk  in  1  board clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  1  raw button, active-high, asynchronous to clk.
- LD1  out  1  LED 1 = pat[3].
- LD2  out  1  LED 2 = pat[2].
- LD3  out  1  LED 3 = pat[1].
- LD4  out  1  LED 4 = pat[0].
- mode  out  2  current mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 COUNT.

## Operation

- Reset (rst_n low, takes effect immediately, no clock needed): pat=4'b0001, mode=0, dir=left, prescaler=0, both synchronizer flops=0, debounce counter=0, debounced state=0.
- Synchronizer: btn passes through two flops to give btn_s.
- Debounce:
  - The counter clears whenever btn_s equals the debounced state, and increments otherwise.
  - When btn_s differs and the counter equals 2^DEBOUNCE_BITS-1, the debounced state takes btn_s and the counter clears.
  - press is asserted in that cycle only when the new state is 1. Release generates no event.
  - Holding the button produces exactly one press.
- Prescaler: a LOG2DELAY-bit counter that wraps. tick is asserted when the counter is all-ones.
- Mode FSM: on each press, ROT_L→ROT_R→BOUNCE→COUNT→ROT_L.
- On a mode change, at the same edge:
  - pat loads the initial value of the new mode.
  - dir is set to left.
  - prescaler is cleared to 0.
- Step rules, applied on tick when there is no press:
  - ROT_L: initial 0001. pat ← {pat[2:0],pat[3]}, giving 0001,0010,0100,1000,0001.
  - ROT_R: initial 1000. pat ← {pat[0],pat[3:1]}, giving 1000,0100,0010,0001,1000.
  - BOUNCE: initial 0001, dir=left.
    - With dir=left, shift left. When the result is 1000, set dir=right.
    - With dir=right, shift right. When the result is 0001, set dir=left.
    - The sequence has period 6: 0001,0010,0100,1000,0100,0010,0001,...
  - COUNT: initial 0000. pat ← pat+1, 4-bit, wrapping 1111→0000.
- Simultaneous press and tick: press wins. The new initial value loads and the tick is discarded.
- pat only ever holds legal values in the rotate and bounce modes (exactly one bit set). No illegal-state recovery is required beyond reset.
- btn held through reset release: the button is treated as a fresh press after debounce, so the mode advances once.

## Timing

- LD1..LD4 and mode are driven directly from flops, with no combinational path from btn.
- Steps after reset release (edge 1 = first rising edge with rst_n high): pat steps at edges 2^LOG2DELAY, 2·2^LOG2DELAY, and so on.
- Steps after a mode change at edge E: the first step is at edge E+2^LOG2DELAY.
- Press latency: btn rising before edge k gives btn_s high after edge k+1. The mode changes at edge k+1+2^DEBOUNCE_BITS if btn stays stable.
- A btn pulse shorter than 2^DEBOUNCE_BITS clocks (measured at btn_s) is ignored entirely.
- rst_n asserted mid-operation forces all outputs to their reset values asynchronously. Operation restarts at step 1 on release.

## Test plan

All scenarios use LOG2DELAY=3 and DEBOUNCE_BITS=2.

- Reset/rotate: pulse rst_n low, btn=0.
  - {LD1..LD4}=0001 and mode=0 while in reset.
  - 0010 after edge 8, 0100 after edge 16, 1000 after edge 24, 0001 after edge 32.
- Debounced press: raise btn before edge 10 and hold.
  - mode=1 and pat=1000 after edge 15 (10+1+4), with the prescaler cleared.
  - pat=0100 after edge 23.
  - Holding btn for 100 further clocks leaves mode=1.
- Glitch rejection: btn high for 3 clocks, then low.
  - mode, pat and step timing are unchanged.
- Bounce: enter BOUNCE via two presses, then run 12 ticks.
  - pat reads 0010,0100,1000,0100,0010,0001,0010,0100,1000,0100,0010,0001.
- Count wrap and press/tick collision:
  - In COUNT, run 17 ticks: pat reaches 1111 then wraps to 0000, then 0001.
  - Time a press to coincide with a tick: mode→0, pat=0001, and the next step is 8 edges later.
- Mid-operation reset: in BOUNCE with pat=0100 and dir=right, assert rst_n for 1 ns between edges.
  - Outputs go to 0001 and mode=0 immediately.
  - After release, the ROT_L schedule of the first scenario is followed exactly.
